// File: rtl/sha256_stream_core_if.sv
// Block-stream bus between the message padder, the SHA-256 core and the digest consumer.
// Optional macro SHA256_SHA224_MODE_EN adds the sel_224 mode select.
interface sha256_stream_core_if;
    logic         valid_in;
    logic         ready_in;
    logic         first_in;
    logic         last_in;
    logic [511:0] data_in;
    logic [255:0] data_out;
    logic         valid_out;
    logic         busy;
`ifdef SHA256_SHA224_MODE_EN
    logic         sel_224;

    modport master (
        output valid_in, first_in, last_in, data_in, sel_224,
        input  ready_in, data_out, valid_out, busy
    );
    modport slave (
        input  valid_in, first_in, last_in, data_in, sel_224,
        output ready_in, data_out, valid_out, busy
    );
`else
    modport master (
        output valid_in, first_in, last_in, data_in,
        input  ready_in, data_out, valid_out, busy
    );
    modport slave (
        input  valid_in, first_in, last_in, data_in,
        output ready_in, data_out, valid_out, busy
    );
`endif
endinterface

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 compression engine with hash chaining across 512-bit blocks.
// ROUNDS_PER_CYCLE (1, 2 or 4) compression rounds are unrolled per clock.
// Optional macro SHA256_SHA224_MODE_EN adds SHA-224 IV selection and truncated output.
module sha256_stream_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input logic                 clk,
    input logic                 rst,
    sha256_stream_core_if.slave bus
);
    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
        $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [255:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA256_SHA224_MODE_EN
    localparam logic [255:0] IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE, ROUND, UPDATE} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // One compression round on the packed working state {a,b,c,d,e,f,g,h}.
    function automatic logic [255:0] round_fn(input logic [255:0] s,
                                              input logic [31:0]  k,
                                              input logic [31:0]  w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    state_t       state;
    logic [6:0]   cnt_q;
    logic         first_q;
    logic         last_q;
    logic         ready_q;
    logic         busy_q;
    logic         valid_q;
    logic [255:0] dout_q;
    logic [255:0] h_q;
    logic [255:0] work_q;
    logic [31:0]  win_q [16];

    logic         accept;
    logic [31:0]  ext [20];
    logic [31:0]  win_next [16];
    logic [255:0] work_next;
    logic [255:0] base;
    logic [255:0] h_new;
    logic [255:0] iv_acc;
    logic [255:0] iv_msg;
    logic [255:0] digest;

`ifdef SHA256_SHA224_MODE_EN
    logic         mode_q;

    assign iv_acc = bus.sel_224 ? IV224 : IV256;
    assign iv_msg = mode_q ? IV224 : IV256;
    assign digest = mode_q ? {h_new[255:32], 32'h0} : h_new;
`else
    assign iv_acc = IV256;
    assign iv_msg = IV256;
    assign digest = h_new;
`endif

    assign accept        = (state == IDLE) && bus.valid_in;
    assign bus.ready_in  = ready_q;
    assign bus.busy      = busy_q;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = dout_q;

    // Extend the schedule by R words and run R chained rounds for this edge.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = win_q[i];
        for (int i = 16; i < 20; i++) ext[i] = 32'h0;
        for (int j = 0; j < R; j++) begin
            ext[16 + j] = ssig1(ext[14 + j]) + ext[9 + j] + ssig0(ext[1 + j]) + ext[j];
        end
        for (int i = 0; i < 16; i++) win_next[i] = ext[i + R];
        work_next = work_q;
        for (int j = 0; j < R; j++) begin
            work_next = round_fn(work_next, K_ROM[cnt_q[5:0] + 6'(j)], ext[j]);
        end
    end

    // Feed-forward addition of the chaining base into the final working state.
    always_comb begin
        base  = first_q ? iv_msg : h_q;
        h_new = '0;
        for (int i = 0; i < 8; i++) begin
            h_new[255 - 32*i -: 32] = base[255 - 32*i -: 32] + work_q[255 - 32*i -: 32];
        end
    end

    // Datapath: load the block and starting state on accept, advance during rounds.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 16; i++) win_q[i] <= bus.data_in[511 - 32*i -: 32];
            work_q <= bus.first_in ? iv_acc : h_q;
        end else if (state == ROUND) begin
            for (int i = 0; i < 16; i++) win_q[i] <= win_next[i];
            work_q <= work_next;
        end
    end

    // Control FSM with registered handshake outputs, chain and digest registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            h_q     <= IV256;
`ifdef SHA256_SHA224_MODE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        first_q <= bus.first_in;
                        last_q  <= bus.last_in;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= ROUND;
`ifdef SHA256_SHA224_MODE_EN
                        if (bus.first_in) mode_q <= bus.sel_224;
`endif
                    end
                end
                ROUND: begin
                    cnt_q <= cnt_q + 7'(R);
                    if (cnt_q == 7'(64 - R)) state <= UPDATE;
                end
                UPDATE: begin
                    h_q     <= h_new;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                    if (last_q) begin
                        dout_q  <= digest;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_stream_core.sv
// Scoreboard bench for sha256_stream_core: three instances (R=1, 2, 4) share one
// stimulus driver; dsel picks the instance that is driven and observed.
module tb_sha256_stream_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         valid = 1'b0;
    logic         first = 1'b0;
    logic         last  = 1'b0;
    logic [511:0] data  = '0;
    logic         sel   = 1'b0;
    int           dsel  = 0;

    logic         ready, busy, vout;
    logic [255:0] dout;

    sha256_stream_core_if bus1 ();
    sha256_stream_core_if bus2 ();
    sha256_stream_core_if bus4 ();

    sha256_stream_core #(.ROUNDS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sha256_stream_core #(.ROUNDS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    sha256_stream_core #(.ROUNDS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus1.valid_in = valid && (dsel == 0);
    assign bus2.valid_in = valid && (dsel == 1);
    assign bus4.valid_in = valid && (dsel == 2);
    assign bus1.first_in = first;
    assign bus2.first_in = first;
    assign bus4.first_in = first;
    assign bus1.last_in  = last;
    assign bus2.last_in  = last;
    assign bus4.last_in  = last;
    assign bus1.data_in  = data;
    assign bus2.data_in  = data;
    assign bus4.data_in  = data;
`ifdef SHA256_SHA224_MODE_EN
    assign bus1.sel_224  = sel;
    assign bus2.sel_224  = sel;
    assign bus4.sel_224  = sel;
`endif

    always_comb begin
        ready = bus1.ready_in;
        busy  = bus1.busy;
        vout  = bus1.valid_out;
        dout  = bus1.data_out;
        if (dsel == 1) begin
            ready = bus2.ready_in;
            busy  = bus2.busy;
            vout  = bus2.valid_out;
            dout  = bus2.data_out;
        end else if (dsel == 2) begin
            ready = bus4.ready_in;
            busy  = bus4.busy;
            vout  = bus4.valid_out;
            dout  = bus4.data_out;
        end
    end

    typedef struct {
        logic [255:0] dig;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_acc = 0;

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_224   = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;

    logic [511:0] blk_abc, blk_empty, blk_two1, blk_two2;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pop and compare whenever the observed instance reports a digest.
    always @(negedge clk) begin
        if (vout === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid_out", 256'(vout), 256'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("digest", dout, e.dig);
                check_eq("latency", 256'(cyc), 256'(e.due));
            end
        end
    end

    function automatic int lat_of(input int sel_dut);
        return (sel_dut == 0) ? 65 : (sel_dut == 1) ? 33 : 17;
    endfunction

    task automatic send(input logic [511:0] blk, input bit f, input bit l, input bit push,
                        input logic [255:0] exp, input bit hold);
        bit got_it;
        got_it = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b1;
        data  = blk;
        first = f;
        last  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                got_it = 1'b1;
                break;
            end
        end
        check_eq("accept", 256'(got_it), 256'(1));
        if (got_it) begin
            last_acc = cyc + 1;
            if (push) sb.push_back('{dig: exp, due: last_acc + lat_of(dsel)});
            @(posedge clk);
            #1;
        end
        if (!hold || !got_it) valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && busy === 1'b0) break;
        end
        check_eq("drain", 256'(sb.size()), 256'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1;
        blk_abc   = {32'h61626380, 416'h0, 64'h18};
        blk_empty = {32'h80000000, 480'h0};
        blk_two1  = {128'h61626364626364656364656664656667,
                     128'h65666768666768696768696a68696a6b,
                     128'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f,
                     128'h6d6e6f706e6f70718000000000000000};
        blk_two2  = {448'h0, 64'h1c0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready_r1", 256'(bus1.ready_in), 256'(1));
        check_eq("rst_busy_r1", 256'(bus1.busy), 256'(0));
        check_eq("rst_vout_r1", 256'(bus1.valid_out), 256'(0));
        check_eq("rst_dout_r1", bus1.data_out, 256'(0));
        check_eq("rst_ready_r2", 256'(bus2.ready_in), 256'(1));
        check_eq("rst_busy_r2", 256'(bus2.busy), 256'(0));
        check_eq("rst_vout_r2", 256'(bus2.valid_out), 256'(0));
        check_eq("rst_dout_r2", bus2.data_out, 256'(0));
        check_eq("rst_ready_r4", 256'(bus4.ready_in), 256'(1));
        check_eq("rst_busy_r4", 256'(bus4.busy), 256'(0));
        check_eq("rst_vout_r4", 256'(bus4.valid_out), 256'(0));
        check_eq("rst_dout_r4", bus4.data_out, 256'(0));

        // "abc" single block, R=1
        dsel = 0;
        send(blk_abc, 1'b1, 1'b1, 1'b1, D_ABC, 1'b0);
        drain();

        // empty message, R=4
        dsel = 2;
        send(blk_empty, 1'b1, 1'b1, 1'b1, D_EMPTY, 1'b0);
        drain();

        // two-block message, R=2; no digest after the first block
        dsel = 1;
        send(blk_two1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        send(blk_two2, 1'b0, 1'b1, 1'b1, D_TWO, 1'b0);
        drain();

        // back-to-back "abc" with valid_in held high, R=1
        dsel = 0;
        send(blk_abc, 1'b1, 1'b1, 1'b1, D_ABC, 1'b1);
        acc1 = last_acc;
        send(blk_abc, 1'b1, 1'b1, 1'b1, D_ABC, 1'b0);
        check_eq("b2b_spacing", 256'(last_acc - acc1), 256'(66));
        drain();

        // reset in the middle of the rounds discards the block
        send(blk_abc, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 256'(ready), 256'(1));
        check_eq("post_rst_busy", 256'(busy), 256'(0));
        repeat (80) @(negedge clk);
        send(blk_abc, 1'b1, 1'b1, 1'b1, D_ABC, 1'b0);
        drain();

        // first_in=0 right after reset chains from the IV
        dsel = 2;
        send(blk_empty, 1'b0, 1'b1, 1'b1, D_EMPTY, 1'b0);
        drain();

`ifdef SHA256_SHA224_MODE_EN
        dsel = 0;
        sel  = 1'b1;
        send(blk_abc, 1'b1, 1'b1, 1'b1, D_224, 1'b0);
        drain();
        sel  = 1'b0;
        send(blk_abc, 1'b1, 1'b1, 1'b1, D_ABC, 1'b0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sha256_stream_core.md
Name: sha256_stream_core

Overview:
- Multi-block SHA-256 compression engine with valid/ready input handshake and hash chaining across 512-bit blocks.
- Unrolls a configurable number of rounds per clock.
- Takes pre-padded blocks with first/last markers; emits the 256-bit digest after the last block.
- Successor to the single-block sha256_top; sits between the message padder and the digest consumer.

Parameters:
- ROUNDS_PER_CYCLE, 1: compression rounds per clock. Legal values are 1, 2 and 4; any other value is an elaboration error. R denotes this value below.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- valid_in  input  1  block present on data_in
- ready_in  output  1  core can accept a block
- first_in  input  1  block starts a new message (chain restarts from IV); sampled on accept
- last_in  input  1  block ends the message (digest emitted); sampled on accept
- data_in  input  512  padded block, word W0 at [511:480], big-endian bytes
- data_out  output  256  digest H0 at [255:224]; holds until next valid_out
- valid_out  output  1  one-cycle pulse, data_out valid
- busy  output  1  block in progress

Behaviour:
- Reset: one clk edge with rst=1. Resulting state:
  - FSM in IDLE; ready_in=1, busy=0, valid_out=0, data_out=0.
  - Chain registers H0..H7 = SHA-256 IV.
  - Reset mid-block discards the block; no valid_out.
- Handshake: a block is accepted on an edge where valid_in & ready_in (edge E0). ready_in=1 only in IDLE. valid_in while ready_in=0 is ignored and must be held by the source.
- FSM states:
  - IDLE: on accept, latch data_in into the 16-word schedule window. Load working vars a..h from IV if first_in=1, else from H. Latch last_in. Go to ROUND, round counter=0.
  - ROUND: R rounds per edge, counter += R. Schedule window slides R words per edge, with W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] mod 2^32. Edges E1..E(64/R). After counter reaches 64, go to UPDATE.
  - UPDATE (edge E(64/R+1)):
    - Hi = base_i + working var, mod 2^32, where base_i = IV_i if first_in was latched, else Hi.
    - If last was latched: data_out=new H and valid_out=1 for exactly one cycle; H then stays as is and the next block must carry first_in=1.
    - Go to IDLE.
- Latency: valid_out high in the cycle after edge E(64/R+1), i.e. 65 cycles after accept for R=1, 33 for R=2, 17 for R=4.
- Throughput: next accept possible on E(64/R+2). ready_in is low from E0 through E(64/R+1).
- busy = not IDLE.
- Arithmetic: all additions mod 2^32; K constants are a 64-entry ROM indexed by round counter.
- Chaining boundaries:
  - first_in=1 and last_in=1 together: single-block message.
  - first_in=0 on the first block after reset or after a completed message: chain continues from the current H (IV after reset). Defined, not an error.
- Simultaneous events: rst wins over accept/UPDATE. valid_out never coincides with ready_in dropping for a new accept in the same cycle as UPDATE.

Optional Feature:
- Macro: SHA256_SHA224_MODE_EN.
- When defined:
  - Adds input port sel_224 (1 bit), sampled with first_in on accept.
  - When the sampled sel_224=1, the chain starts from the SHA-224 IV.
  - At the final UPDATE, data_out[255:32] = H0..H6 and data_out[31:0] = 0.
  - The mode stays fixed for the rest of that message.
- When undefined: no sel_224 port; SHA-256 only; no SHA-224 IV logic present.

Test Plan:
- "abc" single block (data_in=616263800…0018, first=last=1), R=1 -> data_out = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; valid_out exactly 65 cycles after accept, one cycle wide.
- Empty message (block 8000…0000, first=last=1), R=4 -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855; latency 17 cycles.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Block 1 with first=1,last=0; block 2 with first=0,last=1; R=2.
  - No valid_out after block 1; after block 2 -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Back-to-back two "abc" messages with valid_in held high -> second accept occurs exactly 66 cycles after the first (R=1); both digests match "abc".
- Reset asserted at round 30 of an "abc" block -> no valid_out; ready_in=1 the cycle after reset. A following "abc" block yields the correct digest.
- SHA256_SHA224_MODE_EN defined, sel_224=1, "abc" -> data_out = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000.
